// File: rtl/binary_addsub_pipe_if.sv
// rtl/binary_addsub_pipe_if.sv - operand/result handshake bundle for binary_addsub_pipe
//
// Purpose: groups the input beat channel and the result channel of the
// pipelined adder/subtractor.
//
// Signals:
//   in_valid  / in_ready   operand beat handshake (master drives in_valid)
//   a, b                   operands, WIDTH bits
//   sub                    0: a+b+cin, 1: a-b
//   cin                    carry-in, add mode only
//   out_valid / out_ready  result handshake (master drives out_ready)
//   s, cout, ovf           result, carry out of MSB, signed overflow
//
// Modports: master = traffic source/sink, slave = the adder pipe.

interface binary_addsub_pipe_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/binary_addsub_pipe.sv
// rtl/binary_addsub_pipe.sv - segmented, pipelined two's-complement adder/subtractor
//
// Purpose: adds or subtracts two WIDTH-bit operands, resolving one SEG_W-bit
// segment per pipeline stage with a ripple carry registered between stages.
// Latency is STAGES = WIDTH/SEG_W cycles, throughput one beat per cycle.
// The whole pipe advances only when the output slot is free or being taken.
//
// Parameters: WIDTH (multiple of SEG_W), SEG_W.
// Optional build macro: BADD_SATURATE_EN - clamps s to the signed limit on
// overflow (cout/ovf still report the raw condition).
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of binary_addsub_pipe_if (operands in, result out)

module binary_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  binary_addsub_pipe_if.slave  bus
);

  localparam int STAGES = WIDTH / SEG_W;

  logic             adv;
  logic             out_valid;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtraction is A + ~B + 1; the +1 rides in on the stage-0 carry.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub | bus.cin;

  // One global enable: the pipe moves only if the last slot is empty or leaving.
  assign adv          = bus.out_ready | ~out_valid;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // UP_W: operand bits still unresolved on entry to this stage.
    // LO_W: result bits resolved once this stage has registered.
    localparam int UP_W = WIDTH - k * SEG_W;
    localparam int LO_W = (k + 1) * SEG_W;

    logic [UP_W-1:0]  a_up;
    logic [UP_W-1:0]  b_up;
    logic             c_in;
    logic             v_d;
    logic [SEG_W:0]   seg_sum;
    logic [LO_W-1:0]  s_raw;
    logic [LO_W-1:0]  s_d;
    logic [LO_W-1:0]  s_q;
    logic             c_d;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_head
      assign a_up  = bus.a;
      assign b_up  = b_eff;
      assign c_in  = c_eff;
      assign v_d   = bus.in_valid & adv;
      assign s_raw = seg_sum[SEG_W-1:0];
    end else begin : g_body
      assign a_up  = g_stg[k-1].g_skew.a_hi_q;
      assign b_up  = g_stg[k-1].g_skew.b_hi_q;
      assign c_in  = g_stg[k-1].c_q;
      assign v_d   = g_stg[k-1].v_q;
      // Low segments already resolved upstream pass straight through.
      assign s_raw = {seg_sum[SEG_W-1:0], g_stg[k-1].s_q};
    end

    assign seg_sum = {1'b0, a_up[SEG_W-1:0]} + {1'b0, b_up[SEG_W-1:0]}
                   + {{SEG_W{1'b0}}, c_in};
    assign c_d     = seg_sum[SEG_W];

    if (k < STAGES - 1) begin : g_skew
      // Skew registers delay the operand bits later stages still need.
      logic [UP_W-SEG_W-1:0] a_hi_d;
      logic [UP_W-SEG_W-1:0] b_hi_d;
      logic [UP_W-SEG_W-1:0] a_hi_q;
      logic [UP_W-SEG_W-1:0] b_hi_q;

      assign a_hi_d = a_up[UP_W-1:SEG_W];
      assign b_hi_d = b_up[UP_W-1:SEG_W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (adv) begin
          a_hi_q <= a_hi_d;
          b_hi_q <= b_hi_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic c_msb;
      logic ovf_d;
      logic ovf_q;

      // Carry into bit WIDTH-1 recovered from the MSB's own sum bit.
      assign c_msb = a_up[SEG_W-1] ^ b_up[SEG_W-1] ^ seg_sum[SEG_W-1];
      assign ovf_d = c_msb ^ seg_sum[SEG_W];

`ifdef BADD_SATURATE_EN
      // On overflow both addends share A's sign, so A's sign is the true sign.
      assign s_d = ovf_d ? {a_up[SEG_W-1], {(WIDTH-1){~a_up[SEG_W-1]}}} : s_raw;
`else
      assign s_d = s_raw;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end else begin : g_mid
      assign s_d = s_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        s_q <= s_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end
  end

  assign out_valid     = g_stg[STAGES-1].v_q;
  assign bus.out_valid = out_valid;
  assign bus.s         = g_stg[STAGES-1].s_q;
  assign bus.cout      = g_stg[STAGES-1].c_q;
  assign bus.ovf       = g_stg[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_binary_addsub_pipe.sv
// tb/tb_binary_addsub_pipe.sv - self-checking bench for binary_addsub_pipe

`timescale 1ns/1ps

module tb_binary_addsub_pipe;

  localparam int     WIDTH  = 16;
  localparam int     SEG_W  = 4;
  localparam int     STAGES = WIDTH / SEG_W;
  localparam longint MASK   = (longint'(1) << WIDTH) - 1;
  localparam longint MAXP   = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint MINN   = -(longint'(1) << (WIDTH - 1));

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  binary_addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

  binary_addsub_pipe #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int               errors    = 0;
  int               checks    = 0;
  int               n_results = 0;
  logic             accepted;
  logic [WIDTH+1:0] exp_q[$];

  // Reference: integer arithmetic on the operand values, result packed {s, cout, ovf}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic sub, input logic cin);
    longint           ua, ub, raw, sa, sb, tr;
    logic [WIDTH-1:0] s;
    logic             co, ov;
    ua  = longint'(a);
    ub  = longint'(b);
    raw = sub ? (ua + ((~ub) & MASK) + 1) : (ua + ub + longint'(cin));
    s   = raw[WIDTH-1:0];
    co  = raw[WIDTH];
    sa  = (ua > MAXP) ? ua - (MASK + 1) : ua;
    sb  = (ub > MAXP) ? ub - (MASK + 1) : ub;
    tr  = sub ? (sa - sb) : (sa + sb + longint'(cin));
    ov  = (tr > MAXP) || (tr < MINN);
`ifdef BADD_SATURATE_EN
    if (ov) s = (tr > 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    return {s, co, ov};
  endfunction

  // One clock of traffic: drive at the falling edge, settle, then score the
  // result leaving and record the beat entering on the next rising edge.
  task automatic drive_cycle(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                             input logic isub, input logic icin, input logic iordy);
    logic [WIDTH+1:0] e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.sub       = isub;
    bus.cin       = icin;
    bus.out_ready = iordy;
    #1;
    accepted = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      n_results++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got s=%h cout=%b ovf=%b, required no result", bus.s, bus.cout, bus.ovf);
      end else begin
        e = exp_q.pop_front();
        if ({bus.s, bus.cout, bus.ovf} !== e) begin
          errors++;
          $display("FAIL result: got s=%h cout=%b ovf=%b, required s=%h cout=%b ovf=%b",
                   bus.s, bus.cout, bus.ovf, e[WIDTH+1:2], e[1], e[0]);
        end
      end
    end
    if (iv && bus.in_ready) begin
      exp_q.push_back(model(ia, ib, isub, icin));
      accepted = 1'b1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    checks++; if (bus.s !== '0) begin errors++; $display("FAIL reset_s: got %h, required 0", bus.s); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b, required 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", bus.ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va[4]   = '{16'h00FF, 16'hFFFF, 16'h0005, 16'h8000};
    logic [WIDTH-1:0] vb[4]   = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic             vsub[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef BADD_SATURATE_EN
    logic [WIDTH-1:0] es[4]   = '{16'h0100, 16'h0000, 16'hFFFE, 16'h8000};
`else
    logic [WIDTH-1:0] es[4]   = '{16'h0100, 16'h0000, 16'hFFFE, 16'h7FFF};
`endif
    logic             ec[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic             eo[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    int               lat;
    for (int i = 0; i < 4; i++) begin
      lat = -1;
      drive_cycle(1'b1, va[i], vb[i], vsub[i], 1'b0, 1'b1);
      for (int k = 1; k <= 20; k++) begin
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        if (bus.out_valid) begin
          lat = k;
          break;
        end
      end
      checks++;
      if (lat != STAGES) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, required %0d", i, lat, STAGES);
      end
      checks++;
      if (bus.s !== es[i] || bus.cout !== ec[i] || bus.ovf !== eo[i]) begin
        errors++;
        $display("FAIL directed_value[%0d]: got s=%h cout=%b ovf=%b, required s=%h cout=%b ovf=%b",
                 i, bus.s, bus.cout, bus.ovf, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb;
    for (int i = 0; i < 400; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: rb = '1;
        2: ra = {1'b1, {(WIDTH-1){1'b0}}};
        3: rb = {1'b0, {(WIDTH-1){1'b1}}};
        default: ;
      endcase
      drive_cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int               j, base;
    logic             ordy;
    logic [WIDTH-1:0] held_s, a_v, b_v;
    j      = 0;
    base   = n_results;
    held_s = '0;
    a_v    = WIDTH'($urandom);
    b_v    = WIDTH'($urandom);
    for (int cyc = 0; cyc < 40 && j < 8; cyc++) begin
      ordy = !(cyc >= 5 && cyc <= 7);
      drive_cycle(1'b1, a_v, b_v, cyc[0], cyc[1], ordy);
      if (cyc == 5) held_s = bus.s;
      if (cyc >= 5 && cyc <= 7) begin
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_handshake[%0d]: got in_ready=%b out_valid=%b, required 0/1", cyc, bus.in_ready, bus.out_valid);
        end
        if (cyc > 5) begin
          checks++;
          if (bus.s !== held_s) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got s=%h, required %h", cyc, bus.s, held_s);
          end
        end
      end
      if (accepted) begin
        j++;
        a_v = WIDTH'($urandom);
        b_v = WIDTH'($urandom);
      end
    end
    drain();
    checks++;
    if (n_results - base != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 8", n_results - base);
    end
  endtask

  task automatic test_reset_midflight();
    int base;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b, required 0", bus.out_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_ghost[%0d]: got out_valid=%b, required 0", i, bus.out_valid); end
    end
    base = n_results;
    drive_cycle(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1);
    drain();
    checks++;
    if (n_results - base != 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d results, required 1", n_results - base);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
